// File: rtl/quadra_seq_ctrl.sv
// Quadratic approximation sequencer: y = A + B*x + C*x^2 on one shared signed multiplier.
// Define QUADRA_SAT_EN to saturate y on overflow and expose the ovf flag; default build wraps.
module quadra_seq_ctrl #(
   parameter int X_W    = 16,
   parameter int Y_W    = 20,
   parameter int Y_FRAC = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [X_W-1:0] x,
   input  logic [Y_W-1:0] a_coef,
   input  logic [Y_W-1:0] b_coef,
   input  logic [Y_W-1:0] c_coef,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [Y_W-1:0] y,
   output logic           busy
`ifdef QUADRA_SAT_EN
   ,
   output logic           ovf
`endif
);

   localparam int P_W = X_W + Y_W + 1;

   // x squared is zero-extended into the coefficient operand, so it must be strictly narrower.
   if (Y_FRAC > Y_W || Y_W <= X_W) begin : g_param_check
      $error("quadra_seq_ctrl: unsupported X_W/Y_W/Y_FRAC combination");
   end

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SQ    = 3'd1,
      MUL_C = 3'd2,
      MUL_B = 3'd3,
      SUM   = 3'd4,
      HOLD  = 3'd5
   } state_t;

   state_t                state;
   logic        [X_W-1:0] x_r;
   logic        [X_W-1:0] sq_r;
   logic signed [Y_W-1:0] a_r;
   logic signed [Y_W-1:0] b_r;
   logic signed [Y_W-1:0] c_r;
   logic signed [Y_W:0]   t1_r;
   logic signed [Y_W:0]   t2_r;

   logic signed [X_W:0]   mul_a;
   logic signed [Y_W-1:0] mul_b;
   logic signed [P_W-1:0] mul_p;
   logic signed [Y_W:0]   mul_sh;

   // Operand selection depends on the state alone; the single multiplier serves all three terms.
   always_comb begin
      // NOTE: defaults first so every path assigns both operands and no latch is inferred.
      mul_a = '0;
      mul_b = '0;
      case (state)
         SQ: begin
            mul_a = {1'b0, x_r};
            mul_b = {{(Y_W-X_W){1'b0}}, x_r};
         end
         MUL_C: begin
            mul_a = {1'b0, sq_r};
            mul_b = c_r;
         end
         MUL_B: begin
            mul_a = {1'b0, x_r};
            mul_b = b_r;
         end
         default: ;
      endcase
   end

   assign mul_p  = P_W'(mul_a) * P_W'(mul_b);
   // Dropping X_W fractional bits realigns every product to the Y_FRAC grid of A.
   assign mul_sh = (Y_W+1)'(mul_p >>> X_W);

`ifdef QUADRA_SAT_EN
   localparam logic [Y_W-1:0] Y_MAX = {1'b0, {(Y_W-1){1'b1}}};
   localparam logic [Y_W-1:0] Y_MIN = {1'b1, {(Y_W-1){1'b0}}};

   logic signed [Y_W+1:0] sum;
   logic                  sum_ovf;

   assign sum     = (Y_W+2)'(a_r) + (Y_W+2)'(t1_r) + (Y_W+2)'(t2_r);
   // In range only when the top three bits are a pure sign extension.
   assign sum_ovf = (sum[Y_W+1:Y_W-1] != 3'b000) && (sum[Y_W+1:Y_W-1] != 3'b111);
`else
   logic signed [Y_W-1:0] sum;

   assign sum = a_r + Y_W'(t1_r) + Y_W'(t2_r);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         y         <= '0;
         x_r       <= '0;
         sq_r      <= '0;
         a_r       <= '0;
         b_r       <= '0;
         c_r       <= '0;
         t1_r      <= '0;
         t2_r      <= '0;
`ifdef QUADRA_SAT_EN
         ovf       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  x_r      <= x;
                  a_r      <= a_coef;
                  b_r      <= b_coef;
                  c_r      <= c_coef;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= SQ;
               end
            end
            SQ: begin
               sq_r  <= mul_sh[X_W-1:0];
               state <= MUL_C;
            end
            MUL_C: begin
               t2_r  <= mul_sh;
               state <= MUL_B;
            end
            MUL_B: begin
               t1_r  <= mul_sh;
               state <= SUM;
            end
            SUM: begin
`ifdef QUADRA_SAT_EN
               if (sum_ovf) begin
                  y   <= sum[Y_W+1] ? Y_MIN : Y_MAX;
                  ovf <= 1'b1;
               end else begin
                  y   <= sum[Y_W-1:0];
                  ovf <= 1'b0;
               end
`else
               y <= sum;
`endif
               out_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
`ifdef QUADRA_SAT_EN
                  ovf       <= 1'b0;
`endif
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_quadra_seq_ctrl.sv
// Bench for quadra_seq_ctrl: directed vectors with literal results plus a per-cycle
// transaction-level model (QUADRA_SAT_EN selects the saturating expectations).
module tb_quadra_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [15:0] x = '0;
   logic [19:0] a_coef = '0;
   logic [19:0] b_coef = '0;
   logic [19:0] c_coef = '0;
   logic        in_ready;
   logic        out_valid;
   logic        busy;
   logic [19:0] y;
`ifdef QUADRA_SAT_EN
   logic        ovf;
`endif

   quadra_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .a_coef    (a_coef),
      .b_coef    (b_coef),
      .c_coef    (c_coef),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .busy      (busy)
`ifdef QUADRA_SAT_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Fixed-point reference: x has 16 fractional bits, A/B/C/y have 16 of 20.
   function automatic logic [20:0] ref_result(input logic [15:0] xv, input logic [19:0] av,
                                              input logic [19:0] bv, input logic [19:0] cv);
      longint      xs, sq, t1, t2, sum;
      logic [63:0] s_bits;
      logic [19:0] yv;
      logic        ov;
      xs     = longint'(xv);
      sq     = (xs * xs) >> 16;
      t2     = (sq * longint'($signed(cv))) >>> 16;
      t1     = (xs * longint'($signed(bv))) >>> 16;
      sum    = longint'($signed(av)) + t1 + t2;
      s_bits = sum;
      yv     = s_bits[19:0];
      ov     = 1'b0;
`ifdef QUADRA_SAT_EN
      if (sum > 524287) begin
         yv = 20'h7FFFF;
         ov = 1'b1;
      end else if (sum < -524288) begin
         yv = 20'h80000;
         ov = 1'b1;
      end
`endif
      return {ov, yv};
   endfunction

   // Transaction model: one operand set in flight, result visible 4 edges after acceptance.
   int          cyc = 0;
   bit          m_busy = 1'b0;
   int          m_age = 0;
   logic [19:0] m_y = '0;
   logic        m_ovf = 1'b0;
   int          out_hs[$];
   bit          cmp_en = 1'b0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         m_busy <= 1'b0;
      end else if (m_busy) begin
         if (m_age >= 4 && out_ready) begin
            m_busy <= 1'b0;
            out_hs.push_back(cyc);
         end else begin
            m_age <= m_age + 1;
         end
      end else if (in_valid) begin
         m_busy         <= 1'b1;
         m_age          <= 0;
         {m_ovf, m_y}   <= ref_result(x, a_coef, b_coef, c_coef);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("in_ready", in_ready, !m_busy);
         check("busy", busy, m_busy);
         check("out_valid", out_valid, m_busy && m_age >= 4);
         if (m_busy && m_age >= 4) check("y", y, m_y);
`ifdef QUADRA_SAT_EN
         check("ovf", ovf, (m_busy && m_age >= 4) ? m_ovf : 1'b0);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] xv, input logic [19:0] av,
                       input logic [19:0] bv, input logic [19:0] cv);
      int n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      check("send in_ready", in_ready, 1'b1);
      x        = xv;
      a_coef   = av;
      b_coef   = bv;
      c_coef   = cv;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_out();
      int n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      check("out_valid arrives", out_valid, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [20:0] r;
      int          base;
      int          accepted;
      int          n;
      int          gap0;
      bit          take;

      // Pin the model itself against hand-computed values.
      r = ref_result(16'h8000, 20'h00000, 20'h10000, 20'h10000);
      check("model basic", r[19:0], 20'h0C000);
      r = ref_result(16'h8000, 20'h00000, 20'h00000, 20'hF0000);
      check("model negC", r[19:0], 20'hFC000);
      r = ref_result(16'h8000, 20'h7FFFF, 20'h10000, 20'h00000);
`ifdef QUADRA_SAT_EN
      check("model ovf", r, {1'b1, 20'h7FFFF});
`else
      check("model ovf", r, {1'b0, 20'h87FFF});
`endif

      // Reset state.
      rst = 1'b1;
      tick();
      cmp_en = 1'b1;
      tick();
      check("rst in_ready", in_ready, 1'b1);
      check("rst out_valid", out_valid, 1'b0);
      check("rst y", y, 20'h0);
      check("rst busy", busy, 1'b0);
`ifdef QUADRA_SAT_EN
      check("rst ovf", ovf, 1'b0);
`endif
      rst = 1'b0;
      tick();

      // Basic vector with exact latency.
      out_ready = 1'b1;
      send(16'h8000, 20'h00000, 20'h10000, 20'h10000);
      for (int k = 1; k <= 4; k++) begin
         check("basic in_ready low", in_ready, 1'b0);
         check("basic out_valid timing", out_valid, 1'b0);
         tick();
      end
      check("basic out_valid at 4", out_valid, 1'b1);
      check("basic y", y, 20'h0C000);
      tick();
      check("basic in_ready after", in_ready, 1'b1);
      check("basic out_valid drop", out_valid, 1'b0);

      // Negative C.
      send(16'h8000, 20'h00000, 20'h00000, 20'hF0000);
      wait_out();
      check("negC y", y, 20'hFC000);
      tick();

      // x at both extremes.
      send(16'hFFFF, 20'h00000, 20'h00000, 20'h10000);
      wait_out();
      check("xmax y", y, 20'h0FFFE);
      tick();
      send(16'h0000, 20'h5A5A5, 20'h7FFFF, 20'h80000);
      wait_out();
      check("x0 y", y, 20'h5A5A5);
      tick();

      // Back-pressure with a second request waiting.
      out_ready = 1'b0;
      send(16'h8000, 20'h00000, 20'h10000, 20'h10000);
      wait_out();
      base = out_hs.size();
      for (int i = 0; i < 10; i++) begin
         check("bp y stable", y, 20'h0C000);
         check("bp out_valid", out_valid, 1'b1);
         check("bp in_ready", in_ready, 1'b0);
         x        = 16'h4000;
         a_coef   = 20'h00100;
         b_coef   = 20'h00000;
         c_coef   = 20'h10000;
         in_valid = 1'b1;
         tick();
      end
      out_ready = 1'b1;
      tick();
      check("bp one handshake", out_hs.size() - base, 1);
      check("bp in_ready next", in_ready, 1'b1);
      check("bp out_valid drop", out_valid, 1'b0);
      tick();
      in_valid = 1'b0;
      wait_out();
      check("bp held request y", y, 20'h01100);
      tick();

      // Overflow.
      send(16'h8000, 20'h7FFFF, 20'h10000, 20'h00000);
      wait_out();
`ifdef QUADRA_SAT_EN
      check("ovf y", y, 20'h7FFFF);
      check("ovf flag", ovf, 1'b1);
      tick();
      check("ovf cleared", ovf, 1'b0);
`else
      check("wrap y", y, 20'h87FFF);
      tick();
`endif

      // Reset while in MUL_C.
      send(16'h8000, 20'h00000, 20'h10000, 20'h10000);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort in_ready", in_ready, 1'b1);
      check("abort out_valid", out_valid, 1'b0);
      check("abort busy", busy, 1'b0);
      for (int i = 0; i < 8; i++) begin
         check("abort no pulse", out_valid, 1'b0);
         tick();
      end
      send(16'h0000, 20'h00123, 20'($urandom), 20'($urandom));
      wait_out();
      check("after abort y", y, 20'h00123);
      tick();

      // Streaming random vectors with in_valid and out_ready held high.
      base     = out_hs.size();
      accepted = 0;
      n        = 0;
      x        = 16'($urandom);
      a_coef   = 20'($urandom);
      b_coef   = 20'($urandom);
      c_coef   = 20'($urandom);
      in_valid = 1'b1;
      while ((accepted < 20 || out_hs.size() - base < 20) && n < 400) begin
         take = in_valid && in_ready;
         tick();
         n++;
         if (take) begin
            accepted++;
            if (accepted < 20) begin
               x      = 16'($urandom);
               a_coef = 20'($urandom);
               b_coef = 20'($urandom);
               c_coef = 20'($urandom);
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      check("stream count", out_hs.size() - base, 20);
      if (out_hs.size() - base >= 2) begin
         gap0 = out_hs[base+1] - out_hs[base];
         check("stream gap min", gap0 >= 5, 1'b1);
         for (int i = base + 2; i < out_hs.size(); i++)
            check("stream gap steady", out_hs[i] - out_hs[i-1], gap0);
      end

      tick();
      tick();
      cmp_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
